// File: rtl/frame_buffer_scan_controller.sv
// Initiator for the 3x3 ring-of-rows frame buffer: writes the raster pixel stream,
// then scans each fully surrounded center row and qualifies the buffer's matrix output.
module frame_buffer_scan_controller #(
  parameter int P_COLUMNS      = 640,
  parameter int P_ROWS         = 4,
  parameter int P_PIXEL_DEPTH  = 4,
  parameter int P_COLUMNS_BITS = $clog2(P_COLUMNS),
  parameter int P_ROWS_BITS    = $clog2(P_ROWS)
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET_N,
  input  logic [P_PIXEL_DEPTH-1:0]  I_PIXEL,
  input  logic                      I_PIXEL_VALID,
  output logic                      O_PIXEL_READY,
  output logic [P_COLUMNS_BITS-1:0] O_BUF_COLUMN,
  output logic [P_ROWS_BITS-1:0]    O_BUF_ROW,
  output logic [P_PIXEL_DEPTH-1:0]  O_BUF_PIXEL,
  output logic                      O_BUF_WRITE_ENABLE,
  output logic                      O_BUF_READ_ENABLE,
  input  logic                      I_MATRIX_READY,
  output logic                      O_MATRIX_VALID,
  output logic [P_ROWS_BITS-1:0]    O_MATRIX_ROW,
  output logic [P_COLUMNS_BITS-1:0] O_MATRIX_COLUMN,
  output logic                      O_MATRIX_LAST
);

  localparam logic [P_COLUMNS_BITS-1:0] LP_COL_LAST = P_COLUMNS_BITS'(P_COLUMNS - 1);
  localparam logic [P_ROWS_BITS-1:0]    LP_ROW_LAST = P_ROWS_BITS'(P_ROWS - 1);

  typedef enum logic {S_FILL, S_SCAN} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [P_COLUMNS_BITS-1:0] r_wr_col;
  logic [P_ROWS_BITS-1:0]    r_wr_row;
  logic [P_COLUMNS_BITS-1:0] r_scan_col;
  logic [P_ROWS_BITS-1:0]    r_center_row;
  logic [1:0]                r_rows_complete;
  logic                      r_matrix_valid;
  logic [P_ROWS_BITS-1:0]    r_matrix_row;
  logic [P_COLUMNS_BITS-1:0] r_matrix_col;
  logic                      r_matrix_last;

  logic                      w_accept;
  logic                      w_issue;
  logic                      w_row_done;
  logic                      w_scan_start;
  logic                      w_scan_done;
  logic [P_ROWS_BITS-1:0]    w_center_next;

  always_comb begin
    w_accept      = I_PIXEL_VALID & (r_state == S_FILL);
    w_issue       = (r_state == S_SCAN) & (~r_matrix_valid | I_MATRIX_READY);
    w_row_done    = w_accept & (r_wr_col == LP_COL_LAST);
    // rows_complete still holds the pre-increment count, so >=2 means this row makes three
    w_scan_start  = w_row_done & (r_rows_complete >= 2'd2);
    w_scan_done   = w_issue & (r_scan_col == LP_COL_LAST);
    w_center_next = (r_wr_row == '0) ? LP_ROW_LAST : r_wr_row - P_ROWS_BITS'(1);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_scan_start) w_state_next = S_SCAN;
      S_SCAN:  if (w_scan_done)  w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) r_state <= S_FILL;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_wr_col        <= '0;
      r_wr_row        <= '0;
      r_rows_complete <= '0;
    end else if (w_accept) begin
      if (w_row_done) begin
        r_wr_col <= '0;
        r_wr_row <= (r_wr_row == LP_ROW_LAST) ? '0 : r_wr_row + P_ROWS_BITS'(1);
        if (r_rows_complete != 2'd3) r_rows_complete <= r_rows_complete + 2'd1;
      end else begin
        r_wr_col <= r_wr_col + P_COLUMNS_BITS'(1);
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_scan_col   <= '0;
      r_center_row <= '0;
    end else if (w_scan_start) begin
      r_scan_col   <= '0;
      r_center_row <= w_center_next;
    end else if (w_issue) begin
      r_scan_col <= w_scan_done ? '0 : r_scan_col + P_COLUMNS_BITS'(1);
    end
  end

  // The buffer output is registered; metadata tracks the read issued one cycle earlier.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_matrix_valid <= 1'b0;
      r_matrix_row   <= '0;
      r_matrix_col   <= '0;
      r_matrix_last  <= 1'b0;
    end else if (w_issue) begin
      r_matrix_valid <= 1'b1;
      r_matrix_row   <= r_center_row;
      r_matrix_col   <= r_scan_col;
      r_matrix_last  <= (r_scan_col == LP_COL_LAST);
    end else if (I_MATRIX_READY) begin
      r_matrix_valid <= 1'b0;
    end
  end

  always_comb begin
    O_PIXEL_READY      = (r_state == S_FILL);
    O_BUF_WRITE_ENABLE = w_accept;
    O_BUF_READ_ENABLE  = w_issue;
    O_BUF_PIXEL        = I_PIXEL;
    O_BUF_ROW          = (r_state == S_FILL) ? r_wr_row : r_center_row;
    O_BUF_COLUMN       = (r_state == S_FILL) ? r_wr_col : r_scan_col;
    O_MATRIX_VALID     = r_matrix_valid;
    O_MATRIX_ROW       = r_matrix_row;
    O_MATRIX_COLUMN    = r_matrix_col;
    O_MATRIX_LAST      = r_matrix_last;
  end

endmodule

// File: tb/tb_frame_buffer_scan_controller.sv
// Scoreboard bench for frame_buffer_scan_controller with an 8-column, 4-row ring.
module tb_frame_buffer_scan_controller;
  localparam int C = 8;
  localparam int R = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         I_RESET_N;
  logic [D-1:0] I_PIXEL;
  logic         I_PIXEL_VALID;
  logic         O_PIXEL_READY;
  logic [2:0]   O_BUF_COLUMN;
  logic [1:0]   O_BUF_ROW;
  logic [D-1:0] O_BUF_PIXEL;
  logic         O_BUF_WRITE_ENABLE;
  logic         O_BUF_READ_ENABLE;
  logic         I_MATRIX_READY;
  logic         O_MATRIX_VALID;
  logic [1:0]   O_MATRIX_ROW;
  logic [2:0]   O_MATRIX_COLUMN;
  logic         O_MATRIX_LAST;

  always #5 clk = ~clk;

  frame_buffer_scan_controller #(
    .P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(D)
  ) dut (
    .I_CLK(clk), .I_RESET_N(I_RESET_N), .I_PIXEL(I_PIXEL), .I_PIXEL_VALID(I_PIXEL_VALID),
    .O_PIXEL_READY(O_PIXEL_READY), .O_BUF_COLUMN(O_BUF_COLUMN), .O_BUF_ROW(O_BUF_ROW),
    .O_BUF_PIXEL(O_BUF_PIXEL), .O_BUF_WRITE_ENABLE(O_BUF_WRITE_ENABLE),
    .O_BUF_READ_ENABLE(O_BUF_READ_ENABLE), .I_MATRIX_READY(I_MATRIX_READY),
    .O_MATRIX_VALID(O_MATRIX_VALID), .O_MATRIX_ROW(O_MATRIX_ROW),
    .O_MATRIX_COLUMN(O_MATRIX_COLUMN), .O_MATRIX_LAST(O_MATRIX_LAST)
  );

  typedef struct {
    logic [1:0]   row;
    logic [2:0]   col;
    logic [D-1:0] pix;
    bit           scan;
    logic [1:0]   center;
  } wr_t;

  typedef struct {
    logic [1:0] row;
    logic [2:0] col;
    logic       last;
  } mx_t;

  wr_t          expw[$];
  mx_t          expm[$];
  logic [D-1:0] src[$];
  logic [D-1:0] exp_mem[R][C];
  logic [D-1:0] obs_mem[R][C];

  int         checks = 0;
  int         errors = 0;
  int         tb_wr_row = 0;
  int         rows_done = 0;
  int         cyc = 0;
  int         hold_cnt = 0;
  bit         gap_mode = 0;
  bit         hold_armed = 0;
  bit         reset_armed = 0;
  bit         pend_scan = 0;
  logic [1:0] pend_center = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queues one raster row of stimulus plus the writes and matrices it must cause.
  task automatic push_row();
    wr_t          w;
    mx_t          m;
    logic [D-1:0] p;
    logic [1:0]   center;
    center = 2'((tb_wr_row + R - 1) % R);
    for (int c = 0; c < C; c++) begin
      p        = D'($urandom);
      w.row    = 2'(tb_wr_row);
      w.col    = 3'(c);
      w.pix    = p;
      w.scan   = (c == C - 1) && (rows_done >= 2);
      w.center = center;
      src.push_back(p);
      expw.push_back(w);
      exp_mem[tb_wr_row][c] = p;
    end
    if (rows_done >= 2) begin
      for (int c = 0; c < C; c++) begin
        m.row  = center;
        m.col  = 3'(c);
        m.last = (c == C - 1);
        expm.push_back(m);
      end
    end
    rows_done++;
    tb_wr_row = (tb_wr_row + 1) % R;
  endtask

  task automatic do_reset();
    #3;
    I_RESET_N      = 1'b0;
    I_PIXEL_VALID  = 1'b0;
    I_MATRIX_READY = 1'b1;
    #1;
    check("rst_async_ready", O_PIXEL_READY, 1);
    check("rst_async_mvalid", O_MATRIX_VALID, 0);
    check("rst_async_re", O_BUF_READ_ENABLE, 0);
    check("rst_async_we", O_BUF_WRITE_ENABLE, 0);
    check("rst_async_brow", O_BUF_ROW, 0);
    check("rst_async_bcol", O_BUF_COLUMN, 0);
    check("rst_async_mrow", O_MATRIX_ROW, 0);
    check("rst_async_mcol", O_MATRIX_COLUMN, 0);
    check("rst_async_mlast", O_MATRIX_LAST, 0);
    src.delete();
    expw.delete();
    expm.delete();
    tb_wr_row   = 0;
    rows_done   = 0;
    pend_scan   = 0;
    reset_armed = 0;
    repeat (2) @(posedge clk);
    #1;
    I_RESET_N = 1'b1;
  endtask

  // One iteration per clock, entered 1 time unit after the rising edge.
  task automatic run(input int budget);
    int  n;
    int  idle;
    wr_t w;
    mx_t m;
    n    = 0;
    idle = 0;
    while (idle < 3) begin
      if (reset_armed && O_MATRIX_VALID && O_MATRIX_COLUMN == 3'd4) begin
        do_reset();
        return;
      end
      if (hold_armed && O_MATRIX_VALID && O_MATRIX_COLUMN == 3'd3) begin
        hold_armed = 0;
        hold_cnt   = 5;
      end
      I_MATRIX_READY = (hold_cnt == 0);
      I_PIXEL_VALID  = (src.size() > 0) && (!gap_mode || (cyc % 3 == 0));
      I_PIXEL        = (src.size() > 0) ? src[0] : '0;
      #1;
      if (O_BUF_WRITE_ENABLE && O_BUF_READ_ENABLE)
        check("we_re_exclusive", {O_BUF_WRITE_ENABLE, O_BUF_READ_ENABLE}, 2'b10);
      if (pend_scan) begin
        pend_scan = 0;
        check("scan_start_ready", O_PIXEL_READY, 0);
        check("scan_start_read", O_BUF_READ_ENABLE, 1);
        check("scan_start_row", O_BUF_ROW, pend_center);
        check("scan_start_col", O_BUF_COLUMN, 0);
      end
      if (!I_PIXEL_VALID) check("no_write_without_valid", O_BUF_WRITE_ENABLE, 0);
      if (O_BUF_WRITE_ENABLE) begin
        if (expw.size() == 0) begin
          check("unexpected_write", O_BUF_WRITE_ENABLE, 0);
        end else begin
          w = expw.pop_front();
          check("write_row_col_pix", {O_BUF_ROW, O_BUF_COLUMN, O_BUF_PIXEL}, {w.row, w.col, w.pix});
          obs_mem[O_BUF_ROW][O_BUF_COLUMN] = O_BUF_PIXEL;
          if (src.size() > 0) void'(src.pop_front());
          if (w.scan) begin
            pend_scan   = 1;
            pend_center = w.center;
          end
        end
      end
      if (hold_cnt > 0) begin
        check("hold_valid", O_MATRIX_VALID, 1);
        check("hold_col", O_MATRIX_COLUMN, 3);
        check("hold_no_read", O_BUF_READ_ENABLE, 0);
        hold_cnt--;
      end else if (O_MATRIX_VALID) begin
        if (expm.size() == 0) begin
          check("unexpected_matrix", O_MATRIX_VALID, 0);
        end else begin
          m = expm.pop_front();
          check("matrix_row_col_last", {O_MATRIX_ROW, O_MATRIX_COLUMN, O_MATRIX_LAST},
                {m.row, m.col, m.last});
          if (m.last) check("ready_after_scan", O_PIXEL_READY, 1);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      n++;
      if (n > budget) begin
        check("timeout", n, budget);
        break;
      end
      if (src.size() == 0 && expm.size() == 0 && hold_cnt == 0 && !pend_scan) idle++;
      else idle = 0;
    end
  endtask

  initial begin
    I_RESET_N      = 1'b1;
    I_PIXEL        = '0;
    I_PIXEL_VALID  = 1'b0;
    I_MATRIX_READY = 1'b1;
    #1;
    I_RESET_N = 1'b0;
    #1;
    check("reset_ready", O_PIXEL_READY, 1);
    check("reset_mvalid", O_MATRIX_VALID, 0);
    check("reset_we", O_BUF_WRITE_ENABLE, 0);
    check("reset_re", O_BUF_READ_ENABLE, 0);
    check("reset_brow", O_BUF_ROW, 0);
    check("reset_bcol", O_BUF_COLUMN, 0);
    repeat (2) @(posedge clk);
    #1;
    I_RESET_N = 1'b1;

    // Three rows prime the ring; center row 1 is then scanned.
    repeat (3) push_row();
    run(200);

    // Backpressure while column 3 is presented.
    hold_armed = 1;
    push_row();
    run(200);
    check("hold_seen", hold_armed, 0);

    // Rows 5 and 6: write row wraps 3->0, centers 3 then 0.
    repeat (2) push_row();
    run(400);

    // Gapped valid stream, then full buffer contents.
    gap_mode = 1;
    repeat (2) push_row();
    run(400);
    gap_mode = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        check("buffer_contents", obs_mem[r][c], exp_mem[r][c]);

    // Asynchronous reset while column 4 is presented.
    push_row();
    reset_armed = 1;
    run(200);
    check("reset_seen", reset_armed, 0);

    // Two rows after reset must not start a scan.
    repeat (2) push_row();
    run(200);
    repeat (3) begin
      #1;
      check("no_scan_ready", O_PIXEL_READY, 1);
      check("no_scan_read", O_BUF_READ_ENABLE, 0);
      @(posedge clk);
      #1;
      cyc++;
    end

    // The third row re-primes the ring.
    push_row();
    run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
